cpu_state_sequencer: RTL and testbench
======================================

CPU_STATE_SEQUENCER -- requirements
Module: cpu_state_sequencer

Interface
REQ-001 The block SHALL have a parameter TIMEOUT, default 256, meaning the number of consecutive stalled bus cycles before a bus timeout is declared.
REQ-002 clk  input  1  single clock for the block; all state updates occur on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 waitrequest  input  1  Avalon stall from memory.
REQ-005 memread  input  1  control-unit read request in the current state.
REQ-006 memwrite  input  1  control-unit write request in the current state.
REQ-007 div_mult_busy  input  1  multiply/divide unit still computing.
REQ-008 pc_next_zero  input  1  the PC value written at exec2 completion is 0x00000000.
REQ-009 state  output  4  0=HALT, 1=FETCH, 2=DECODE, 3=EXEC1, 4=EXEC2; drives the control unit's state input.
REQ-010 active  output  1  CPU running, i.e. state != HALT.
REQ-011 bus_timeout  output  1  sticky error flag.
REQ-012 instr_count  output  32  retired instructions.
REQ-013 stall_count  output  32  stalled cycles.

Function
REQ-014 Nominal sequence SHALL be FETCH->DECODE->EXEC1->EXEC2->FETCH, one cycle per state when not stalled.
REQ-015 Bus stall: in any state, (memread|memwrite)&waitrequest SHALL hold the current state.
REQ-016 EXEC2 SHALL additionally hold while div_mult_busy=1.
REQ-017 DECODE SHALL never stall.
REQ-018 EXEC2 exit with pc_next_zero=1 SHALL go to HALT instead of FETCH.
REQ-019 HALT SHALL be absorbing until reset; all inputs are ignored in HALT.
REQ-020 instr_count SHALL increment by 1 on each non-stalled EXEC2 exit, including the exit to HALT, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-021 stall_count SHALL increment by 1 on each cycle in which the state is held per REQ-015/016, and SHALL saturate at 0xFFFFFFFF.
REQ-022 A run counter SHALL count consecutive bus-stall cycles and SHALL clear on any cycle without a bus stall.
REQ-023 When the run counter reaches TIMEOUT, the block SHALL on that edge set bus_timeout=1, force state=HALT, and stop both counters.
REQ-024 A div_mult_busy-only stall SHALL NOT advance the run counter.
REQ-025 If timeout and pc_next_zero coincide, the block SHALL go to HALT with bus_timeout=1.
REQ-026 active SHALL be combinational from state.

Reset
REQ-027 On a rising edge with reset=1, the block SHALL set state=FETCH, bus_timeout=0, instr_count=0, stall_count=0, and run counter=0; active=1 follows.
REQ-028 Reset SHALL override every other condition, including mid-stall, HALT, and timeout.
REQ-029 No output SHALL be X after the first reset edge.

Structure
REQ-030 The state encoding SHALL be defined as localparams in the shared package cpu_pkg, used by both this block and the control unit.
REQ-031 The 32-bit wrapping and saturating counters SHALL be built from one sub-module, perf_counter, with a parameterised saturate/wrap mode.
REQ-032 The FSM and the timeout run counter SHALL be implemented in the top-level module.

Verification
REQ-033 Reset, then 8 cycles with memread=0 and memwrite=0 -> state 1,2,3,4,1,2,3,4 and instr_count=2.
REQ-034 FETCH with memread=1 and waitrequest=1 for 3 cycles -> state held at 1 for 3 cycles, then 2, with stall_count=3.
REQ-035 EXEC2 with div_mult_busy=1 for 5 cycles and waitrequest=0 -> state held at 4 for 5 cycles, stall_count=5, and bus_timeout stays 0.
REQ-036 EXEC2 exit with pc_next_zero=1 -> state=0, active=0, instr_count incremented by 1, and state stays 0 for 10 further cycles of random inputs.
REQ-037 TIMEOUT=4, EXEC1 with memread=1 and waitrequest held high -> state=0 and bus_timeout=1 after the 4th stalled cycle, with stall_count frozen at 4.
REQ-038 Reset asserted while in EXEC2 mid-stall -> next cycle state=1, all counts 0, and bus_timeout=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU state encoding, counter modes and sequencing helper
package cpu_pkg;

    localparam logic [3:0] ST_HALT   = 4'd0;
    localparam logic [3:0] ST_FETCH  = 4'd1;
    localparam logic [3:0] ST_DECODE = 4'd2;
    localparam logic [3:0] ST_EXEC1  = 4'd3;
    localparam logic [3:0] ST_EXEC2  = 4'd4;

    localparam int CNT_W = 32;

    typedef enum logic {
        CNT_WRAP     = 1'b0,
        CNT_SATURATE = 1'b1
    } cnt_mode_e;

    // Unstalled successor of a state; EXEC2 leaves to HALT when the new PC is zero
    function automatic logic [3:0] nominal_next(input logic [3:0] cur, input logic pc_zero);
        case (cur)
            ST_FETCH:  return ST_DECODE;
            ST_DECODE: return ST_EXEC1;
            ST_EXEC1:  return ST_EXEC2;
            ST_EXEC2:  return pc_zero ? ST_HALT : ST_FETCH;
            default:   return ST_HALT;
        endcase
    endfunction

endpackage

// File: rtl/cpu_state_sequencer_if.sv
// rtl/cpu_state_sequencer_if.sv - control/status bundle between the sequencer and the control unit
interface cpu_state_sequencer_if;
    import cpu_pkg::*;

    logic             waitrequest;
    logic             memread;
    logic             memwrite;
    logic             div_mult_busy;
    logic             pc_next_zero;
    logic [3:0]       state;
    logic             active;
    logic             bus_timeout;
    logic [CNT_W-1:0] instr_count;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output waitrequest, memread, memwrite, div_mult_busy, pc_next_zero,
        input  state, active, bus_timeout, instr_count, stall_count
    );

    modport slave (
        input  waitrequest, memread, memwrite, div_mult_busy, pc_next_zero,
        output state, active, bus_timeout, instr_count, stall_count
    );

endinterface

// File: rtl/perf_counter.sv
// rtl/perf_counter.sv - 32-bit event counter, wrapping or saturating
module perf_counter
    import cpu_pkg::*;
#(
    parameter cnt_mode_e MODE = CNT_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic at_limit;

    // Saturating counters stop at all-ones; wrapping counters roll over naturally
    always_comb begin
        at_limit = (MODE == CNT_SATURATE) && (count == '1);
    end

    // Count one per enabled cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (en && !at_limit) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/cpu_state_sequencer.sv
// rtl/cpu_state_sequencer.sv - CPU fetch/decode/execute sequencer with stall accounting and bus timeout
module cpu_state_sequencer
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    cpu_state_sequencer_if.slave  bus
);

    localparam int RUN_W = $clog2(TIMEOUT + 1);

    logic [3:0]       state_q;
    logic [RUN_W-1:0] run_q;
    logic             timeout_q;

    logic running;
    logic bus_stall;
    logic div_stall;
    logic hold;
    logic timeout_hit;
    logic exec2_exit;

    // Stall decode: DECODE never waits on the bus, HALT ignores everything
    always_comb begin
        running     = (state_q != ST_HALT);
        bus_stall   = running && (state_q != ST_DECODE) &&
                      (bus.memread || bus.memwrite) && bus.waitrequest;
        div_stall   = (state_q == ST_EXEC2) && bus.div_mult_busy;
        hold        = bus_stall || div_stall;
        timeout_hit = bus_stall && (run_q == RUN_W'(TIMEOUT - 1));
        exec2_exit  = (state_q == ST_EXEC2) && !hold;
    end

    // Main sequencer: timeout wins over everything except reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
        end else if (timeout_hit) begin
            state_q <= ST_HALT;
        end else if (running && !hold) begin
            state_q <= nominal_next(state_q, bus.pc_next_zero);
        end
    end

    // Consecutive bus-stall run length; any non-bus-stall cycle clears it
    always_ff @(posedge clk) begin
        if (reset) begin
            run_q <= '0;
        end else if (bus_stall) begin
            run_q <= run_q + 1'b1;
        end else begin
            run_q <= '0;
        end
    end

    // Sticky timeout flag
    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_q <= 1'b0;
        end else if (timeout_hit) begin
            timeout_q <= 1'b1;
        end
    end

    perf_counter #(.MODE(CNT_WRAP)) u_instr_count (
        .clk   (clk),
        .reset (reset),
        .en    (exec2_exit),
        .count (bus.instr_count)
    );

    perf_counter #(.MODE(CNT_SATURATE)) u_stall_count (
        .clk   (clk),
        .reset (reset),
        .en    (hold),
        .count (bus.stall_count)
    );

    assign bus.state       = state_q;
    assign bus.active      = running;
    assign bus.bus_timeout = timeout_q;

endmodule

// File: tb/tb_cpu_state_sequencer.sv
// tb/tb_cpu_state_sequencer.sv - self-checking bench for cpu_state_sequencer
module tb_cpu_state_sequencer;

    localparam int TO = 4;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_pass;

    cpu_state_sequencer_if ifc ();

    cpu_state_sequencer #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: states are the integers 0..4, walking 1->2->3->4->1
    int          m_state;
    bit          m_to;
    logic [31:0] m_ic;
    logic [31:0] m_sc;
    int          m_run;
    bit          m_valid;
    bit          m_bs;
    bit          m_held;

    initial m_valid = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_state = 1; m_to = 0; m_ic = 0; m_sc = 0; m_run = 0; m_valid = 1;
        end else if (m_valid && m_state != 0) begin
            m_bs   = (m_state != 2) && (ifc.memread || ifc.memwrite) && ifc.waitrequest;
            m_held = m_bs || (m_state == 4 && ifc.div_mult_busy);
            m_run  = m_bs ? m_run + 1 : 0;
            if (m_held && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
            if (m_bs && m_run == TO) begin
                m_state = 0;
                m_to    = 1;
            end else if (!m_held) begin
                if (m_state == 4) begin
                    m_ic    = m_ic + 1;
                    m_state = ifc.pc_next_zero ? 0 : 1;
                end else begin
                    m_state = m_state + 1;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_state",  {28'd0, ifc.state}, 32'(m_state));
            chk("m_active", {31'd0, ifc.active}, {31'd0, m_state != 0});
            chk("m_tmo",    {31'd0, ifc.bus_timeout}, {31'd0, m_to});
            chk("m_instr",  ifc.instr_count, m_ic);
            chk("m_stall",  ifc.stall_count, m_sc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ifc.memread = 0; ifc.memwrite = 0; ifc.waitrequest = 0;
        ifc.div_mult_busy = 0; ifc.pc_next_zero = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        step();
        reset = 0;
    endtask

    int exp_seq [8] = '{1, 2, 3, 4, 1, 2, 3, 4};

    initial begin
        n_chk = 0; n_pass = 0;
        reset = 1;
        idle_inputs();
        step();
        reset = 0;
        chk("rst_state", {28'd0, ifc.state}, 32'd1);
        chk("rst_active", {31'd0, ifc.active}, 32'd1);
        chk("rst_tmo", {31'd0, ifc.bus_timeout}, 32'd0);
        chk("rst_instr", ifc.instr_count, 32'd0);
        chk("rst_stall", ifc.stall_count, 32'd0);

        // Nominal loop
        for (int i = 0; i < 8; i++) begin
            chk("seq_state", {28'd0, ifc.state}, 32'(exp_seq[i]));
            step();
        end
        chk("seq_instr", ifc.instr_count, 32'd2);

        // FETCH bus stall for 3 cycles
        do_reset();
        ifc.memread = 1; ifc.waitrequest = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fetch_hold", {28'd0, ifc.state}, 32'd1);
        end
        idle_inputs();
        step();
        chk("fetch_rel", {28'd0, ifc.state}, 32'd2);
        chk("fetch_stall", ifc.stall_count, 32'd3);

        // EXEC2 multiply/divide stall, longer than the bus timeout
        do_reset();
        repeat (3) step();
        ifc.div_mult_busy = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("div_hold", {28'd0, ifc.state}, 32'd4);
        end
        chk("div_stall", ifc.stall_count, 32'd5);
        idle_inputs();
        step();
        chk("div_rel", {28'd0, ifc.state}, 32'd1);
        chk("div_tmo", {31'd0, ifc.bus_timeout}, 32'd0);
        chk("div_instr", ifc.instr_count, 32'd1);

        // EXEC2 exit to HALT, then HALT ignores inputs
        do_reset();
        repeat (3) step();
        ifc.pc_next_zero = 1;
        step();
        chk("halt_state", {28'd0, ifc.state}, 32'd0);
        chk("halt_active", {31'd0, ifc.active}, 32'd0);
        chk("halt_instr", ifc.instr_count, 32'd1);
        for (int i = 0; i < 10; i++) begin
            ifc.memread = 1'($urandom); ifc.memwrite = 1'($urandom);
            ifc.waitrequest = 1'($urandom); ifc.div_mult_busy = 1'($urandom);
            ifc.pc_next_zero = 1'($urandom);
            step();
            chk("halt_abs", {28'd0, ifc.state}, 32'd0);
        end
        chk("halt_instr2", ifc.instr_count, 32'd1);

        // Bus timeout in EXEC1
        do_reset();
        repeat (2) step();
        ifc.memread = 1; ifc.waitrequest = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("to_hold", {28'd0, ifc.state}, 32'd3);
            chk("to_flag0", {31'd0, ifc.bus_timeout}, 32'd0);
        end
        step();
        chk("to_state", {28'd0, ifc.state}, 32'd0);
        chk("to_flag", {31'd0, ifc.bus_timeout}, 32'd1);
        chk("to_stall", ifc.stall_count, 32'd4);
        repeat (2) step();
        chk("to_frozen", ifc.stall_count, 32'd4);
        chk("to_sticky", {31'd0, ifc.bus_timeout}, 32'd1);

        // Reset in the middle of an EXEC2 stall
        do_reset();
        repeat (3) step();
        ifc.memwrite = 1; ifc.waitrequest = 1;
        repeat (2) step();
        chk("mid_hold", {28'd0, ifc.state}, 32'd4);
        reset = 1;
        step();
        reset = 0;
        chk("mid_state", {28'd0, ifc.state}, 32'd1);
        chk("mid_instr", ifc.instr_count, 32'd0);
        chk("mid_stall", ifc.stall_count, 32'd0);
        chk("mid_tmo", {31'd0, ifc.bus_timeout}, 32'd0);
        idle_inputs();

        // Randomized traffic, checked cycle by cycle by the model
        for (int i = 0; i < 4000; i++) begin
            reset             = ($urandom_range(0, 39) == 0);
            ifc.memread       = ($urandom_range(0, 2) == 0);
            ifc.memwrite      = ($urandom_range(0, 3) == 0);
            ifc.waitrequest   = ($urandom_range(0, 9) < 6);
            ifc.div_mult_busy = ($urandom_range(0, 3) == 0);
            ifc.pc_next_zero  = ($urandom_range(0, 7) == 0);
            step();
        end
        reset = 0;
        idle_inputs();
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
